// File: rtl/register_bridge.sv
// Packet-to-register-bus bridge: parses UART command packets into register reads/writes
// and returns read data. Define REG_BRIDGE_WRITE_ACK_EN to answer every write with 0xAA.
module register_bridge #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic [7:0]  ipRxData,
    input  logic        ipRxValid,
    output logic [7:0]  opTxData,
    output logic        opTxSend,
    input  logic        ipTxBusy,
    output logic [7:0]  opReadAddress,
    output logic [7:0]  opWriteAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable,
    input  logic [31:0] ipRdData
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
`ifdef REG_BRIDGE_WRITE_ACK_EN
    localparam logic [7:0] ACK_BYTE  = 8'hAA;
`endif

    typedef enum logic [2:0] {
        IDLE, GET_CMD, GET_ADDR, GET_DATA, WRITE, READ_WAIT, READ_CAPTURE, SEND
    } state_t;

    state_t        state_q, state_d;
    logic          isWrite_q, isWrite_d;
    logic [7:0]    addr_q, addr_d;
    logic [1:0]    byteCnt_q, byteCnt_d;
    logic [23:0]   dataShift_q, dataShift_d;
    logic [7:0]    wrAddr_q, wrAddr_d;
    logic [31:0]   wrData_q, wrData_d;
    logic [7:0]    rdAddr_q, rdAddr_d;
    logic [31:0]   txShift_q, txShift_d;
    logic [2:0]    txLeft_q, txLeft_d;
    logic          txSend_q, txSend_d;
    logic [7:0]    txData_q, txData_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          timedOut;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q     <= IDLE;
            isWrite_q   <= 1'b0;
            addr_q      <= '0;
            byteCnt_q   <= '0;
            dataShift_q <= '0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            rdAddr_q    <= '0;
            txShift_q   <= '0;
            txLeft_q    <= '0;
            txSend_q    <= 1'b0;
            txData_q    <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            isWrite_q   <= isWrite_d;
            addr_q      <= addr_d;
            byteCnt_q   <= byteCnt_d;
            dataShift_q <= dataShift_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            rdAddr_q    <= rdAddr_d;
            txShift_q   <= txShift_d;
            txLeft_q    <= txLeft_d;
            txSend_q    <= txSend_d;
            txData_q    <= txData_d;
            timeout_q   <= timeout_d;
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timedOut = !ipRxValid && (timeout_q == TIMEOUT_LAST);

    always_comb begin
        state_d     = state_q;
        isWrite_d   = isWrite_q;
        addr_d      = addr_q;
        byteCnt_d   = byteCnt_q;
        dataShift_d = dataShift_q;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        rdAddr_d    = rdAddr_q;
        txShift_d   = txShift_q;
        txLeft_d    = txLeft_q;
        txSend_d    = txSend_q;
        txData_d    = txData_q;
        if (ipRxValid)
            timeout_d = '0;
        else if (timeout_q == TIMEOUT_LAST)
            timeout_d = timeout_q;
        else
            timeout_d = timeout_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (ipRxValid && ipRxData == SYNC_BYTE)
                    state_d = GET_CMD;
            end
            GET_CMD: begin
                if (ipRxValid) begin
                    if (ipRxData == CMD_READ || ipRxData == CMD_WRITE) begin
                        isWrite_d = ipRxData[0];
                        state_d   = GET_ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timedOut) begin
                    state_d = IDLE;
                end
            end
            GET_ADDR: begin
                if (ipRxValid) begin
                    if (isWrite_q) begin
                        addr_d    = ipRxData;
                        byteCnt_d = '0;
                        state_d   = GET_DATA;
                    end else begin
                        rdAddr_d = ipRxData;
                        state_d  = READ_WAIT;
                    end
                end else if (timedOut) begin
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                // Write address/data are staged and only committed once the packet is complete.
                if (ipRxValid) begin
                    dataShift_d = {ipRxData, dataShift_q[23:8]};
                    byteCnt_d   = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        wrAddr_d = addr_q;
                        wrData_d = {ipRxData, dataShift_q};
                        state_d  = WRITE;
                    end
                end else if (timedOut) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
`ifdef REG_BRIDGE_WRITE_ACK_EN
                txShift_d = {24'h000000, ACK_BYTE};
                txLeft_d  = 3'd1;
                state_d   = SEND;
`else
                state_d = IDLE;
`endif
            end
            READ_WAIT: state_d = READ_CAPTURE;
            READ_CAPTURE: begin
                txShift_d = ipRdData;
                txLeft_d  = 3'd4;
                state_d   = SEND;
            end
            SEND: begin
                // Request drops for one cycle after each accepted byte.
                if (txSend_q) begin
                    if (!ipTxBusy) begin
                        txSend_d  = 1'b0;
                        txShift_d = {8'h00, txShift_q[31:8]};
                        txLeft_d  = txLeft_q - 3'd1;
                        if (txLeft_q == 3'd1)
                            state_d = IDLE;
                    end
                end else begin
                    txSend_d = 1'b1;
                    txData_d = txShift_q[7:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign opTxData       = txData_q;
    assign opTxSend       = txSend_q;
    assign opReadAddress  = rdAddr_q;
    assign opWriteAddress = wrAddr_q;
    assign opWrData       = wrData_q;
    assign opWrEnable     = (state_q == WRITE);

endmodule

// File: tb/tb_register_bridge.sv
// Self-checking bench for register_bridge: table of packets plus hand-written
// sequences for transmit back-pressure, timeout boundaries and mid-packet reset.
module tb_register_bridge;

   localparam int TIMEOUT = 20;
`ifdef REG_BRIDGE_WRITE_ACK_EN
   localparam int          ACK_N    = 1;
   localparam logic [31:0] ACK_WORD = 32'h000000AA;
`else
   localparam int          ACK_N    = 0;
   localparam logic [31:0] ACK_WORD = 32'h00000000;
`endif

   logic        ipClk;
   logic        ipReset;
   logic [7:0]  ipRxData;
   logic        ipRxValid;
   logic [7:0]  opTxData;
   logic        opTxSend;
   logic        ipTxBusy;
   logic [7:0]  opReadAddress;
   logic [7:0]  opWriteAddress;
   logic [31:0] opWrData;
   logic        opWrEnable;
   logic [31:0] ipRdData;

   register_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .ipClk(ipClk),
      .ipReset(ipReset),
      .ipRxData(ipRxData),
      .ipRxValid(ipRxValid),
      .opTxData(opTxData),
      .opTxSend(opTxSend),
      .ipTxBusy(ipTxBusy),
      .opReadAddress(opReadAddress),
      .opWriteAddress(opWriteAddress),
      .opWrData(opWrData),
      .opWrEnable(opWrEnable),
      .ipRdData(ipRdData)
   );

   initial ipClk = 1'b0;
   always #5 ipClk = ~ipClk;

   // Register block model: registered read data, writes land on the strobe.
   logic [31:0] regs [256];
   always @(posedge ipClk) begin
      if (opWrEnable) regs[opWriteAddress] <= opWrData;
      ipRdData <= regs[opReadAddress];
   end

   int          vectors;
   int          miscompares;
   int          wrCount;
   logic [7:0]  capAddr;
   logic [31:0] capData;
   logic [7:0]  txq [$];
   int          protoErrors;
   logic        prevSend, prevAcc;
   logic [7:0]  prevData;

   // Observes write strobes, accepted TX bytes and the transmit handshake rules.
   always @(negedge ipClk) begin
      if (ipReset) begin
         prevSend = 1'b0;
         prevAcc  = 1'b0;
      end else begin
         if (opWrEnable) begin
            wrCount++;
            capAddr = opWriteAddress;
            capData = opWrData;
         end
         if (prevSend && !prevAcc && (!opTxSend || opTxData !== prevData)) protoErrors++;
         if (prevAcc && opTxSend) protoErrors++;
         if (opTxSend && !ipTxBusy) txq.push_back(opTxData);
         prevSend = opTxSend;
         prevAcc  = opTxSend && !ipTxBusy;
         prevData = opTxData;
      end
   end

   typedef struct {
      int          nBytes;
      logic [79:0] pkt;
      int          expWr;
      logic [7:0]  expWrAddr;
      logic [31:0] expWrData;
      logic [7:0]  expRdAddr;
      int          expTx;
      logic [31:0] expTxWord;
   } vec_t;

   vec_t vecs [9];

   function automatic vec_t mk(input int n, input logic [79:0] p, input int w,
                               input logic [7:0] wa, input logic [31:0] wd,
                               input logic [7:0] ra, input int t, input logic [31:0] tw);
      vec_t v;
      v.nBytes = n; v.pkt = p; v.expWr = w; v.expWrAddr = wa; v.expWrData = wd;
      v.expRdAddr = ra; v.expTx = t; v.expTxWord = tw;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic sendByte(input logic [7:0] b);
      ipRxValid = 1'b1;
      ipRxData  = b;
      @(posedge ipClk); #1;
      ipRxValid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin @(posedge ipClk); #1; end
   endtask

   task automatic applyStimulus(input logic [79:0] pkt, input int n);
      for (int i = 0; i < n; i++) sendByte(pkt[8*i +: 8]);
   endtask

   task automatic checkTx(input string name, input int n, input logic [31:0] word);
      checkOutput({name, " tx count"}, txq.size(), n);
      for (int i = 0; i < n && i < txq.size(); i++)
         checkOutput({name, " tx byte"}, {24'h0, txq[i]}, {24'h0, word[8*i +: 8]});
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, " opTxSend"},       {31'h0, opTxSend},       32'h0);
      checkOutput({name, " opTxData"},       {24'h0, opTxData},       32'h0);
      checkOutput({name, " opWrEnable"},     {31'h0, opWrEnable},     32'h0);
      checkOutput({name, " opReadAddress"},  {24'h0, opReadAddress},  32'h0);
      checkOutput({name, " opWriteAddress"}, {24'h0, opWriteAddress}, 32'h0);
      checkOutput({name, " opWrData"},       opWrData,                32'h0);
   endtask

   initial begin
      int wrBase;
      int n;
      int holdBad;

      vectors = 0; miscompares = 0; wrCount = 0; protoErrors = 0;
      prevSend = 1'b0; prevAcc = 1'b0; prevData = 8'h00;
      capAddr = 8'h00; capData = 32'h0;
      for (int i = 0; i < 256; i++) regs[i] = 32'h0;
      regs[8'hFF] = 32'hA5A50001;
      ipRdData = 32'h0;
      ipReset = 1'b1; ipRxValid = 1'b0; ipRxData = 8'h00; ipTxBusy = 1'b0;

      vecs[0] = mk(7, 80'h12345678_02_01_55,      1, 8'h02, 32'h12345678, 8'h00, ACK_N, ACK_WORD);
      vecs[1] = mk(3, 80'h02_00_55,               0, 8'h02, 32'h12345678, 8'h02, 4, 32'h12345678);
      vecs[2] = mk(3, 80'h02_07_55,               0, 8'h02, 32'h12345678, 8'h02, 0, 32'h0);
      vecs[3] = mk(9, 80'hDEADBEEF_10_01_55_AA_00, 1, 8'h10, 32'hDEADBEEF, 8'h02, ACK_N, ACK_WORD);
      vecs[4] = mk(3, 80'h10_00_55,               0, 8'h10, 32'hDEADBEEF, 8'h10, 4, 32'hDEADBEEF);
      vecs[5] = mk(3, 80'hFF_00_55,               0, 8'h10, 32'hDEADBEEF, 8'hFF, 4, 32'hA5A50001);
      vecs[6] = mk(7, 80'h55555555_55_01_55,      1, 8'h55, 32'h55555555, 8'hFF, ACK_N, ACK_WORD);
      vecs[7] = mk(4, 80'h02_00_55_55,            0, 8'h55, 32'h55555555, 8'hFF, 0, 32'h0);
      vecs[8] = mk(3, 80'h55_00_55,               0, 8'h55, 32'h55555555, 8'h55, 4, 32'h55555555);

      repeat (3) @(posedge ipClk);
      #1;
      checkResetOutputs("reset");
      ipReset = 1'b0;
      idleCycles(2);

      for (int v = 0; v < 9; v++) begin
         wrBase = wrCount;
         txq.delete();
         applyStimulus(vecs[v].pkt, vecs[v].nBytes);
         idleCycles(30);
         checkOutput($sformatf("vec%0d write pulses", v), wrCount - wrBase, vecs[v].expWr);
         if (vecs[v].expWr > 0) begin
            checkOutput($sformatf("vec%0d strobe addr", v), {24'h0, capAddr}, {24'h0, vecs[v].expWrAddr});
            checkOutput($sformatf("vec%0d strobe data", v), capData, vecs[v].expWrData);
         end
         checkOutput($sformatf("vec%0d opWriteAddress", v), {24'h0, opWriteAddress}, {24'h0, vecs[v].expWrAddr});
         checkOutput($sformatf("vec%0d opWrData", v), opWrData, vecs[v].expWrData);
         checkOutput($sformatf("vec%0d opReadAddress", v), {24'h0, opReadAddress}, {24'h0, vecs[v].expRdAddr});
         checkTx($sformatf("vec%0d", v), vecs[v].expTx, vecs[v].expTxWord);
      end

      // Read with the transmitter busy: latency, address update and held request.
      wrBase = wrCount;
      txq.delete();
      ipTxBusy = 1'b1;
      applyStimulus(80'h02_00_55, 3);
      checkOutput("busy read opReadAddress", {24'h0, opReadAddress}, 32'h02);
      n = 1;
      while (!opTxSend && n < 20) begin @(posedge ipClk); #1; n++; end
      checkOutput("busy read latency", n, 4);
      holdBad = 0;
      for (int i = 0; i < 100; i++) begin
         if (!opTxSend || opTxData !== 8'h78) holdBad++;
         @(posedge ipClk); #1;
      end
      checkOutput("busy hold", holdBad, 0);
      ipTxBusy = 1'b0;
      idleCycles(30);
      checkOutput("busy write pulses", wrCount - wrBase, 0);
      checkTx("busy read", 4, 32'h12345678);

      // Partial write abandoned after a full timeout; trailing bytes must not complete it.
      wrBase = wrCount;
      txq.delete();
      applyStimulus(80'h78_02_01_55, 4);
      idleCycles(TIMEOUT);
      applyStimulus(80'h12_34_56, 3);
      idleCycles(5);
      applyStimulus(80'h02_00_55, 3);
      idleCycles(30);
      checkOutput("timeout write pulses", wrCount - wrBase, 0);
      checkOutput("timeout opWrData", opWrData, 32'h55555555);
      checkTx("timeout read", 4, 32'h12345678);

      // Gaps one cycle short of expiry keep the packet alive.
      wrBase = wrCount;
      txq.delete();
      applyStimulus(80'h11_03_01_55, 4);
      idleCycles(TIMEOUT - 1);
      sendByte(8'h22);
      idleCycles(TIMEOUT - 1);
      sendByte(8'h33);
      idleCycles(TIMEOUT - 1);
      sendByte(8'h44);
      idleCycles(30);
      checkOutput("slow write pulses", wrCount - wrBase, 1);
      checkOutput("slow write addr", {24'h0, capAddr}, 32'h03);
      checkOutput("slow write data", capData, 32'h44332211);
      checkTx("slow write", ACK_N, ACK_WORD);

      // Reset in the middle of the data bytes, then a clean write.
      applyStimulus(80'hBB_AA_04_01_55, 5);
      ipReset = 1'b1;
      @(posedge ipClk); #1;
      checkResetOutputs("mid reset");
      ipReset = 1'b0;
      wrBase = wrCount;
      txq.delete();
      applyStimulus(80'hDD_CC, 2);
      idleCycles(5);
      checkOutput("post reset leftovers", wrCount - wrBase, 0);
      applyStimulus(80'h04030201_06_01_55, 7);
      idleCycles(30);
      checkOutput("post reset write pulses", wrCount - wrBase, 1);
      checkOutput("post reset addr", {24'h0, opWriteAddress}, 32'h06);
      checkOutput("post reset data", opWrData, 32'h04030201);
      checkTx("post reset write", ACK_N, ACK_WORD);

      checkOutput("tx handshake errors", protoErrors, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/register_bridge.md
# register_bridge

Packet-to-register-bus bridge sitting directly upstream of the memory-mapped register block. Parses command packets from the UART receiver into single-cycle register writes and reads. Returns read data, and optionally write acknowledges, to the UART transmitter. Drives the register block's read address, write address, write data and write enable; consumes its registered read data.

## Interface
- TIMEOUT_CYCLES, 50000: idle clock cycles tolerated between bytes of one packet before the parser aborts.
- ipClk  in  1  system clock.
- ipReset  in  1  synchronous, active-high reset.
- ipRxData  in  8  received byte.
- ipRxValid  in  1  one-cycle strobe; ipRxData valid.
- opTxData  out  8  byte to transmit.
- opTxSend  out  1  transmit request.
- ipTxBusy  in  1  transmitter busy.
- opReadAddress  out  8  register read address.
- opWriteAddress  out  8  register write address.
- opWrData  out  32  register write data.
- opWrEnable  out  1  one-cycle write strobe.
- ipRdData  in  32  register read data; valid one cycle after opReadAddress changes.

## Operation
- Packet format: sync 0x55, command, address, then 4 data bytes, LS byte first, for writes only. Command 0x00 is read; 0x01 is write.
- States:
  - IDLE: wait for sync. Any byte other than 0x55 is ignored.
  - GET_CMD: 0x00 or 0x01 -> GET_ADDR; any other value -> IDLE.
  - GET_ADDR: latch the address. A write goes to GET_DATA; a read goes to READ_WAIT.
  - GET_DATA: shift in 4 bytes, LS first. After the 4th byte -> WRITE.
  - WRITE: opWrEnable=1 for exactly one cycle. Then go to SEND (ack only) or IDLE.
  - READ_WAIT: one cycle for register read latency.
  - READ_CAPTURE: latch ipRdData into a 32-bit shift register -> SEND.
  - SEND: transmit the response bytes -> IDLE.
- Read response: 4 bytes, LS first.
- Transmit handshake:
  - A byte is accepted in the cycle where opTxSend=1 and ipTxBusy=0.
  - opTxSend stays high with opTxData stable until accepted.
  - After acceptance, opTxSend is low for at least one cycle before the next byte.
- Bytes arriving in WRITE, READ_WAIT, READ_CAPTURE or SEND are discarded. They are not buffered.
- Timeout:
  - A counter clears on every ipRxValid.
  - In GET_CMD, GET_ADDR or GET_DATA, reaching TIMEOUT_CYCLES-1 with no byte forces IDLE and discards the partial packet.
  - The counter saturates and never wraps.
- opReadAddress holds its last value outside reads. opWriteAddress and opWrData change only on packet reception.

## Timing
- Reset values: state IDLE; opTxSend=0, opTxData=0, opWrEnable=0, opReadAddress=0, opWriteAddress=0, opWrData=0; timeout counter 0.
- Reset mid-packet or mid-send aborts immediately. A byte in flight at the transmitter is its own concern.
- Write: opWrEnable high in the cycle after the ipRxValid of the 4th data byte. opWriteAddress and opWrData are stable in that cycle.
- Read: opReadAddress updates the cycle after the address byte's ipRxValid. ipRdData is sampled 2 cycles after that. opTxSend rises the following cycle.
- Minimum address-byte-to-first-opTxSend latency for reads: 4 cycles.
- ipRxValid in the same cycle as a timeout expiry: the byte wins and the counter clears.
- ipRxValid in the cycle of the final transmit acceptance is discarded (state is SEND).

## Configuration
- REG_BRIDGE_WRITE_ACK_EN defined: after WRITE, SEND transmits one byte 0xAA, then returns to IDLE.
- Not defined: WRITE returns directly to IDLE, and writes produce no transmit traffic.

## Test plan
- Write packet 55 01 02 78 56 34 12 -> exactly one opWrEnable pulse with opWriteAddress=0x02, opWrData=0x12345678. With the macro, one TX byte 0xAA.
- Read packet 55 00 02 with the register model returning 0x12345678 one cycle after address -> TX bytes 78 56 34 12 in order. No opWrEnable.
- ipTxBusy held high 100 cycles during a read response -> opTxSend stays high with opTxData=0x78 throughout. No byte is lost or duplicated.
- Bad command 55 07 02 followed by a valid read -> first packet ignored, read answered normally.
- Partial write 55 01 02 78, then TIMEOUT_CYCLES idle cycles, then a full read -> no write; read answered.
- ipReset asserted during GET_DATA -> all outputs return to reset values the next cycle. A following valid write executes correctly.
